// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw async input into a clean level with rise/fall pulses.
// Latency: dout follows a clean input change SYNC_STAGES + DEBOUNCE_CYCLES - 1 edges later.
// No backpressure; optional glitch counter enabled by INPUT_DEBOUNCER_GLITCH_COUNT_EN.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_async,
    output logic                dout,
    output logic                rise_pulse,
    output logic                fall_pulse,
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    output logic [GLITCH_W-1:0] glitch_count,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               DIRECT   = (DEBOUNCE_CYCLES == 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
        end
    end

    // Single-cycle debounce bypasses the WAIT states entirely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync_in) begin
                        if (DIRECT) begin
                            state      <= IDLE_HIGH;
                            dout       <= 1'b1;
                            rise_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            state <= WAIT_HIGH;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_in) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state      <= IDLE_HIGH;
                        dout       <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_in) begin
                        if (DIRECT) begin
                            state      <= IDLE_LOW;
                            dout       <= 1'b0;
                            fall_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            state <= WAIT_LOW;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                WAIT_LOW: begin
                    if (sync_in) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state      <= IDLE_LOW;
                        dout       <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    logic glitch;

    assign glitch = ((state == WAIT_HIGH) && !sync_in) || ((state == WAIT_LOW) && sync_in);

    always_ff @(posedge clk) begin
        if (!rst) begin
            glitch_count <= '0;
        end else if (glitch && (glitch_count != '1)) begin
            glitch_count <= glitch_count + GLITCH_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: DEBOUNCE_CYCLES=4 and =1 instances share one stimulus stream.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DC_A = 4;
    localparam int DC_B = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_async = 1'b0;
    logic [1:0] dout_v, rise_v, fall_v, busy_v;
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    logic [7:0] gc_a, gc_b;
`endif

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC_A), .CNT_W(8), .GLITCH_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .din_async(din_async),
        .dout(dout_v[0]), .rise_pulse(rise_v[0]), .fall_pulse(fall_v[0]),
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
        .glitch_count(gc_a),
`endif
        .busy(busy_v[0])
    );

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC_B), .CNT_W(8), .GLITCH_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .din_async(din_async),
        .dout(dout_v[1]), .rise_pulse(rise_v[1]), .fall_pulse(fall_v[1]),
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
        .glitch_count(gc_b),
`endif
        .busy(busy_v[1])
    );

    typedef struct {
        logic [1:0] dout;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
        int         gc0;
        int         gc1;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [SYNC-1:0] m_hist = '0;
    int         m_run[2];
    logic       m_dout[2];
    int         m_gc[2];
    logic       busy_seen_b = 1'b0;
    int         rise_cnt_a = 0;

    function automatic int dc_of(input int i);
        return (i == 0) ? DC_A : DC_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: an output flips once dc consecutive sampled values differ from it.
    task automatic model_edge(input logic d, input logic r);
        exp_t e;
        logic s;
        e.rise = '0;
        e.fall = '0;
        if (!r) begin
            m_hist = '0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_dout[i] = 1'b0; m_gc[i] = 0;
            end
        end else begin
            s = m_hist[SYNC-1];
            m_hist = {m_hist[SYNC-2:0], d};
            for (int i = 0; i < 2; i++) begin
                if (s != m_dout[i]) begin
                    m_run[i]++;
                    if (m_run[i] == dc_of(i)) begin
                        m_dout[i] = s;
                        m_run[i] = 0;
                        if (s) e.rise[i] = 1'b1;
                        else   e.fall[i] = 1'b1;
                    end
                end else begin
                    if (m_run[i] > 0 && m_gc[i] < 255) m_gc[i]++;
                    m_run[i] = 0;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            e.dout[i] = m_dout[i];
            e.busy[i] = (m_run[i] > 0);
        end
        e.gc0 = m_gc[0];
        e.gc1 = m_gc[1];
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("dout_a", dout_v[0], e.dout[0]);
        check("rise_a", rise_v[0], e.rise[0]);
        check("fall_a", fall_v[0], e.fall[0]);
        check("busy_a", busy_v[0], e.busy[0]);
        check("dout_b", dout_v[1], e.dout[1]);
        check("rise_b", rise_v[1], e.rise[1]);
        check("fall_b", fall_v[1], e.fall[1]);
        check("busy_b", busy_v[1], e.busy[1]);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
        check("gcount_a", gc_a, e.gc0);
        check("gcount_b", gc_b, e.gc1);
`endif
        busy_seen_b = busy_seen_b | busy_v[1];
        rise_cnt_a += rise_v[0];
    endtask

    task automatic step(input logic d, input logic r);
        @(negedge clk);
        din_async = d;
        rst = r;
        model_edge(d, r);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        int k;
        int lvl;

        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);

        // Clean rise: dout appears after the edge 5 counted from the first sampling edge.
        rise_cnt_a = 0;
        for (k = 1; k <= 40; k++) begin
            step(1'b1, 1'b1);
            if (dout_v[0]) break;
        end
        check("rise_latency", k - 1, 5);
        repeat (6) step(1'b1, 1'b1);
        check("rise_once", rise_cnt_a, 1);

        // Clean fall.
        for (k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1);
            if (!dout_v[0]) break;
        end
        check("fall_latency", k - 1, 5);
        repeat (6) step(1'b0, 1'b1);

        // Two-cycle glitch is rejected.
        repeat (2) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check("glitch_dout", dout_v[0], 0);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
        check("glitch_one", gc_a, 1);
`endif

        // Reset in the middle of a rising qualification.
        repeat (3) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        check("rst_dout", dout_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        for (k = 1; k <= 40; k++) begin
            step(1'b1, 1'b1);
            if (dout_v[0]) break;
        end
        check("rst_latency", k - 1, 5);
        repeat (10) step(1'b0, 1'b1);

        // Chatter: four short random segments, fifth toggle held high.
        rise_cnt_a = 0;
        lvl = 1;
        for (int t = 0; t < 4; t++) begin
            repeat ($urandom_range(1, 3)) step(lvl[0], 1'b1);
            lvl = 1 - lvl;
        end
        repeat (10) step(1'b1, 1'b1);
        check("chatter_one_rise", rise_cnt_a, 1);
        repeat (10) step(1'b0, 1'b1);

        // Single-cycle pulse seen by the DEBOUNCE_CYCLES=1 instance after 2 edges.
        for (k = 1; k <= 10; k++) begin
            step((k == 1) ? 1'b1 : 1'b0, 1'b1);
            if (dout_v[1]) break;
        end
        check("dc1_latency", k - 1, 2);
        repeat (5) step(1'b0, 1'b1);

        // Many glitches drive the counter to saturation.
        for (int g = 0; g < 300; g++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        repeat (4) step(1'b0, 1'b1);
        check("sat_dout", dout_v[0], 0);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
        check("glitch_sat", gc_a, 255);
`endif
        check("dc1_busy_never", busy_seen_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
